fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 128 ++++++++++++
 tb/tb_fifo_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: synchronous single-clock FIFO with registered read data.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : pointer width; depth is 2**ADDR_WIDTH words
//   AF_LEVEL   : almost_full asserts when occupancy >= AF_LEVEL
//   AE_LEVEL   : almost_empty asserts when occupancy <= AE_LEVEL
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   push, pop    : write / read requests
//   data_in      : write data
//   data_out     : read data, loaded on the edge that accepts a pop
//   empty, full  : occupancy == 0 / occupancy == depth
//   almost_empty : occupancy <= AE_LEVEL
//   almost_full  : occupancy >= AF_LEVEL
//   overflow     : one-cycle pulse after a rejected push
//   underflow    : one-cycle pulse after a rejected pop
//   fifo_counter : current occupancy, 0..depth
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   fifo_counter
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Thresholds sized to the counter so the decodes compare like widths.
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic empty_s;
  logic full_s;
  logic push_ok_s;
  logic pop_ok_s;

  // Status decodes and request acceptance.
  always_comb begin
    empty_s   = (count_r == CNT_ZERO);
    full_s    = (count_r == DEPTH_C);
    pop_ok_s  = pop & ~empty_s;
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    push_ok_s = push & (~full_s | pop_ok_s);
  end

  // Storage array: deliberately not reset; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_r[wr_ptr_r] <= data_in;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy, read data and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      data_out_r  <= {DATA_WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= push & ~push_ok_s;
      underflow_r <= pop & ~pop_ok_s;

      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_ok_s) begin
        data_out_r <= mem_r[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
      end else begin
        data_out_r <= data_out_r;
        rd_ptr_r   <= rd_ptr_r;
      end

      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign data_out     = data_out_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign fifo_counter = count_r;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (count_r <= AE_C);
  assign almost_full  = (count_r >= AF_C);

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table-driven directed test of fifo_param with the default
// parameters (8-bit words, depth 8, AF_LEVEL 6, AE_LEVEL 2), plus hand-written
// sequences for reset behaviour.
module tb_fifo_param;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;
  logic [3:0] fifo_counter;

  int total;
  int bad;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    int         cnt;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vec_q[$];

  fifo_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow),
    .fifo_counter(fifo_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic p, input logic q, input logic [7:0] d,
                     input logic [7:0] dout, input int cnt,
                     input logic ovf, input logic udf);
    vec_t v;
    v.push = p; v.pop = q; v.din = d; v.dout = dout;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vec_q.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  // Flags are the documented decodes of the expected occupancy.
  task automatic check_all(input int idx, input logic [7:0] dout, input int cnt,
                           input logic ovf, input logic udf);
    cmp("data_out", idx, int'(data_out), int'(dout));
    cmp("count", idx, int'(fifo_counter), cnt);
    cmp("empty", idx, int'(empty), (cnt == 0) ? 1 : 0);
    cmp("full", idx, int'(full), (cnt == 8) ? 1 : 0);
    cmp("almost_empty", idx, int'(almost_empty), (cnt <= 2) ? 1 : 0);
    cmp("almost_full", idx, int'(almost_full), (cnt >= 6) ? 1 : 0);
    cmp("overflow", idx, int'(overflow), int'(ovf));
    cmp("underflow", idx, int'(underflow), int'(udf));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Fill to full, then one rejected push.
    for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, 8'(k), 8'h00, k, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h09, 8'h00, 8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b0, 1'b0);
    // Drain in order, then one rejected pop.
    for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 8'h00, 8'(k), 8 - k, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 8'h08, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 8'h08, 0, 1'b0, 1'b0);
    // Wrap: offset pointers by 5, then a full lap.
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 8'(8'h11 + k), 8'h08, k + 1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 8'h00, 8'(8'h11 + k), 4 - k, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 8'(8'hA0 + k), 8'h15, k + 1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 8'h00, 8'(8'hA0 + k), 7 - k, 1'b0, 1'b0);
    // Full with simultaneous push and pop.
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 8'(8'hB0 + k), 8'hA7, k + 1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h55, 8'hB0, 8, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 1'b1, 8'h00, 8'(8'hB0 + k), 8 - k, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 8'h55, 0, 1'b0, 1'b0);
    // Empty with simultaneous push and pop.
    add(1'b1, 1'b1, 8'h33, 8'h55, 1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h00, 8'h33, 0, 1'b0, 1'b0);
    // Four words stored ahead of the asynchronous reset.
    for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 8'(8'hC1 + k), 8'h33, k + 1, 1'b0, 1'b0);

    push = 1'b0; pop = 1'b0; data_in = 8'h00;
    rst = 1'b1;
    #1;
    check_all(-1, 8'h00, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all(-2, 8'h00, 0, 1'b0, 1'b0);

    for (int i = 0; i < vec_q.size(); i++) begin
      push    = vec_q[i].push;
      pop     = vec_q[i].pop;
      data_in = vec_q[i].din;
      @(posedge clk);
      #1;
      check_all(i, vec_q[i].dout, vec_q[i].cnt, vec_q[i].ovf, vec_q[i].udf);
    end

    // Asynchronous reset between edges with 4 words stored.
    push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all(1000, 8'h00, 0, 1'b0, 1'b0);
    // Requests on an edge while reset is held are ignored.
    push = 1'b1; pop = 1'b1; data_in = 8'hEE;
    @(posedge clk);
    #1;
    check_all(1001, 8'h00, 0, 1'b0, 1'b0);
    push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b0;
    // First pop after reset finds nothing stored.
    pop = 1'b1;
    @(posedge clk);
    #1;
    check_all(1002, 8'h00, 0, 1'b0, 1'b1);
    pop = 1'b0;
    @(posedge clk);
    #1;
    check_all(1003, 8'h00, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
